core_boot_ctrl: RTL and testbench

Boot and reset sequencer for the RISC-V core. Holds the core in reset and accepts a byte stream (host/UART side) carrying a word count and instruction words. Writes those words into instruction ROM through a write port, then releases the core's rst_n. Also supports reboot on request and error trapping.

---
 rtl/boot_pkg.sv | 23 ++
 rtl/boot_byte_asm.sv | 52 +++++
 rtl/core_boot_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_core_boot_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types for the boot sequencer: FSM state encoding and error codes.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_DATA = 3'd1,
    ST_CHK  = 3'd2,
    ST_HOLD = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } boot_state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_CHK  = 2'd3;

  // States in which the byte stream is being consumed.
  function automatic logic st_rx(boot_state_e s);
    return (s == ST_HDR) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/boot_byte_asm.sv
// Little-endian byte-to-word assembler shared by header, data and checksum.
// word is valid while word_done is high (the cycle after the 4th byte).
module boot_byte_asm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic        done_q, done_d;

  // Place each accepted byte in its lane; pulse done after lane 3.
  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    done_d = 1'b0;
    if (clr) begin
      cnt_d = 2'd0;
    end else if (byte_vld) begin
      case (cnt_q)
        2'd0:    word_d[7:0]   = byte_data;
        2'd1:    word_d[15:8]  = byte_data;
        2'd2:    word_d[23:16] = byte_data;
        default: word_d[31:24] = byte_data;
      endcase
      cnt_d  = cnt_q + 2'd1;
      done_d = (cnt_q == 2'd3);
    end
  end

  // Assembler registers; a reset mid-word discards the partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
      done_q <= done_d;
    end
  end

  assign word      = word_q;
  assign word_done = done_q;

endmodule

// File: rtl/core_boot_ctrl.sv
// Boot/reset sequencer: receives a length-prefixed word stream over a byte
// link, writes it into instruction ROM, then releases the core reset.
// Optional trailing checksum word enabled by defining BOOT_CHECKSUM_EN.
module core_boot_ctrl
  import boot_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int RST_HOLD = 8,
  parameter int TIMEOUT  = 65535
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              InValid,
  input  logic [7:0]        InData,
  output logic              InReady,
  input  logic              Reboot,
  output logic              ROMWE,
  output logic [ADDR_W-1:0] ROMWADDR,
  output logic [31:0]       ROMWData,
  output logic              CoreRstN,
  output logic              Busy,
  output logic              Err,
  output logic [1:0]        ErrCode
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int HW = $clog2(RST_HOLD + 1);
  localparam logic [TW-1:0]     TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]     TMO_ONE   = TW'(1);
  localparam logic [HW-1:0]     HOLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [HW-1:0]     HOLD_ONE  = HW'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [32:0]       LEN_MAX   = 33'(1) << ADDR_W;
`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_e ST_END = ST_CHK;
`else
  localparam boot_state_e ST_END = ST_HOLD;
`endif

  boot_state_e       state_q, state_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              act_q, act_d;
  logic [1:0]        code_q, code_d;
  logic              core_rstn_q, core_rstn_d;
  logic              rdy_en_q, rdy_en_d;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]       sum_q, sum_d;
`endif

  logic        accept, counting, tmo_exp;
  logic [31:0] asm_word;
  logic        asm_done;

  assign accept   = InValid && InReady;
  // Header timeout is armed only once a frame has begun.
  assign counting = (state_q == ST_DATA) || (state_q == ST_CHK) ||
                    ((state_q == ST_HDR) && act_q);
  assign tmo_exp  = counting && !accept && (tmo_q == TMO_LAST);

  boot_byte_asm u_asm (
    .clk       (CLK),
    .rst_n     (rst_n),
    .clr       (!st_rx(state_q)),
    .byte_vld  (accept),
    .byte_data (InData),
    .word      (asm_word),
    .word_done (asm_done)
  );

  // Next-state, counters and error capture.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    last_d      = last_q;
    hold_d      = hold_q;
    tmo_d       = tmo_q;
    act_d       = act_q;
    code_d      = code_q;
    rdy_en_d    = 1'b1;
`ifdef BOOT_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    if (accept) begin
      tmo_d = '0;
      act_d = 1'b1;
    end else if (counting) begin
      tmo_d = tmo_q + TMO_ONE;
    end
    unique case (state_q)
      ST_HDR: begin
        if (asm_done) begin
          wcnt_d = '0;
          last_d = asm_word[ADDR_W-1:0] - ADDR_ONE;
`ifdef BOOT_CHECKSUM_EN
          sum_d  = asm_word;
`endif
          if ({1'b0, asm_word} > LEN_MAX) begin
            state_d = ST_ERR;
            code_d  = ERR_LEN;
          end else if (asm_word == 32'd0) begin
            state_d = ST_END;
          end else begin
            state_d = ST_DATA;
          end
        end else if (tmo_exp) begin
          state_d = ST_ERR;
          code_d  = ERR_TMO;
        end
      end
      ST_DATA: begin
        if (asm_done) begin
          wcnt_d = wcnt_q + ADDR_ONE;
`ifdef BOOT_CHECKSUM_EN
          sum_d  = sum_q + asm_word;
`endif
          if (wcnt_q == last_q) state_d = ST_END;
        end else if (tmo_exp) begin
          state_d = ST_ERR;
          code_d  = ERR_TMO;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      ST_CHK: begin
        if (asm_done) begin
          if (asm_word == sum_q) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_ERR;
            code_d  = ERR_CHK;
          end
        end else if (tmo_exp) begin
          state_d = ST_ERR;
          code_d  = ERR_TMO;
        end
      end
`endif
      ST_HOLD: begin
        tmo_d = '0;
        act_d = 1'b0;
        if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      ST_RUN: begin
        if (Reboot) begin
          state_d = ST_HDR;
          wcnt_d  = '0;
          hold_d  = '0;
          tmo_d   = '0;
          act_d   = 1'b0;
        end
      end
      default: state_d = state_q;
    endcase
    core_rstn_d = (state_d == ST_RUN);
  end

  // Control and counter registers.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HDR;
      wcnt_q      <= '0;
      last_q      <= '0;
      hold_q      <= '0;
      tmo_q       <= '0;
      act_q       <= 1'b0;
      code_q      <= ERR_NONE;
      core_rstn_q <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      tmo_q       <= tmo_d;
      act_q       <= act_d;
      code_q      <= code_d;
      core_rstn_q <= core_rstn_d;
      rdy_en_q    <= rdy_en_d;
    end
  end

`ifdef BOOT_CHECKSUM_EN
  // Running modulo-2^32 sum of the header word and all data words.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) sum_q <= 32'd0;
    else        sum_q <= sum_d;
  end
`endif

  assign InReady  = rdy_en_q && st_rx(state_q);
  assign ROMWE    = asm_done && (state_q == ST_DATA);
  assign ROMWADDR = wcnt_q;
  assign ROMWData = asm_word;
  assign CoreRstN = core_rstn_q;
  assign Busy     = st_rx(state_q) || (state_q == ST_HOLD);
  assign Err      = (state_q == ST_ERR);
  assign ErrCode  = code_q;

endmodule

// File: tb/tb_core_boot_ctrl.sv
// Bench for core_boot_ctrl (ADDR_W=4, RST_HOLD=8, TIMEOUT=16).
module tb_core_boot_ctrl;

  localparam int AW   = 4;
  localparam int HOLD = 8;
  localparam int TMO  = 16;

  logic          CLK = 1'b0;
  logic          rst_n = 1'b0;
  logic          InValid = 1'b0;
  logic [7:0]    InData = 8'h00;
  logic          Reboot = 1'b0;
  logic          InReady, ROMWE, CoreRstN, Busy, Err;
  logic [AW-1:0] ROMWADDR;
  logic [31:0]   ROMWData;
  logic [1:0]    ErrCode;

  int vec_cnt = 0;
  int bad_cnt = 0;

  core_boot_ctrl #(.ADDR_W(AW), .RST_HOLD(HOLD), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .rst_n(rst_n), .InValid(InValid), .InData(InData), .InReady(InReady),
    .Reboot(Reboot), .ROMWE(ROMWE), .ROMWADDR(ROMWADDR), .ROMWData(ROMWData),
    .CoreRstN(CoreRstN), .Busy(Busy), .Err(Err), .ErrCode(ErrCode)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          vld;
    logic [7:0]    dat;
    logic          rb;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          rstn;
    logic          rdy;
    logic          busy;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input int vld, input int dat, input int rb, input int we, input int addr,
                     input logic [31:0] data, input int rstn, input int rdy, input int busy);
    vec_t v;
    v.vld = vld[0]; v.dat = dat[7:0]; v.rb = rb[0]; v.we = we[0]; v.addr = addr[AW-1:0];
    v.data = data; v.rstn = rstn[0]; v.rdy = rdy[0]; v.busy = busy[0];
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Write scoreboard: every ROM write must match the next expected {addr,data}.
  logic mon_en = 1'b0;
  logic [AW+31:0] exp_wr[$];
  always @(negedge CLK) begin
    if (mon_en && ROMWE) begin
      if (exp_wr.size() == 0) begin
        vec_cnt++;
        bad_cnt++;
        $display("FAIL unexpected_write: addr %0d data 0x%0h, no write expected", ROMWADDR, ROMWData);
      end else begin
        logic [AW+31:0] e;
        e = exp_wr.pop_front();
        chk("wr_addr", 32'(ROMWADDR), 32'(e[AW+31:32]));
        chk("wr_data", ROMWData, e[31:0]);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    InValid = 1'b1;
    InData  = b;
    @(negedge CLK);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send(w[8*k +: 8]);
  endtask

  task automatic do_reset();
    InValid = 1'b0;
    Reboot  = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK);
  endtask

  // Header, n data words (expected writes queued), then checksum if built in.
  task automatic frame(input int n, input logic [31:0] seed);
    logic [31:0] w;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0] sum;
    sum = 32'(n);
`endif
    send_word(32'(n));
    for (int i = 0; i < n; i++) begin
      w = seed + 32'(i) * 32'h0101_0101;
`ifdef BOOT_CHECKSUM_EN
      sum = sum + w;
`endif
      exp_wr.push_back({AW'(i), w});
      send_word(w);
    end
`ifdef BOOT_CHECKSUM_EN
    send_word(sum);
`endif
  endtask

  // Called right after the final byte of a frame: the completion cycle plus
  // RST_HOLD hold cycles pass before CoreRstN reads high.
  task automatic expect_release(input string name);
    int k;
    k = 1;
    InValid = 1'b0;
    while (CoreRstN !== 1'b1 && k < 60) begin
      @(negedge CLK);
      k++;
    end
    chk(name, 32'(k), 32'(HOLD + 2));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ---- vector table: boot N=2, then reboot and reload N=1 ----
    add(1, 'h02, 0, 0, 0, 0, 0, 1, 1);
    add(1, 'h00, 1, 0, 0, 0, 0, 1, 1);
    add(1, 'h00, 0, 0, 0, 0, 0, 1, 1);
    add(1, 'h00, 0, 0, 0, 0, 0, 1, 1);
    add(1, 'h13, 0, 0, 0, 0, 0, 1, 1);
    add(1, 'h00, 0, 0, 0, 0, 0, 1, 1);
    add(1, 'h00, 0, 0, 0, 0, 0, 1, 1);
    add(1, 'h00, 0, 0, 0, 0, 0, 1, 1);
    add(1, 'h93, 0, 1, 0, 32'h0000_0013, 0, 1, 1);
    add(1, 'h00, 0, 0, 0, 0, 0, 1, 1);
    add(1, 'h10, 0, 0, 0, 0, 0, 1, 1);
    add(1, 'h00, 0, 0, 0, 0, 0, 1, 1);
`ifdef BOOT_CHECKSUM_EN
    add(1, 'hA8, 0, 1, 1, 32'h0010_0093, 0, 1, 1);
    add(1, 'h00, 0, 0, 0, 0, 0, 1, 1);
    add(1, 'h10, 0, 0, 0, 0, 0, 1, 1);
    add(1, 'h00, 0, 0, 0, 0, 0, 1, 1);
    add(0, 'h00, 0, 0, 0, 0, 0, 1, 1);
`else
    add(0, 'h00, 0, 1, 1, 32'h0010_0093, 0, 1, 1);
`endif
    for (int i = 0; i < HOLD; i++) add(0, 'h00, (i == 3) ? 1 : 0, 0, 0, 0, 0, 0, 1);
    add(0, 'h00, 1, 0, 0, 0, 1, 0, 0);
    add(1, 'h01, 0, 0, 0, 0, 0, 1, 1);
    add(1, 'h00, 0, 0, 0, 0, 0, 1, 1);
    add(1, 'h00, 0, 0, 0, 0, 0, 1, 1);
    add(1, 'h00, 0, 0, 0, 0, 0, 1, 1);
    add(1, 'hEF, 0, 0, 0, 0, 0, 1, 1);
    add(1, 'hBE, 0, 0, 0, 0, 0, 1, 1);
    add(1, 'hAD, 0, 0, 0, 0, 0, 1, 1);
    add(1, 'hDE, 0, 0, 0, 0, 0, 1, 1);
`ifdef BOOT_CHECKSUM_EN
    add(1, 'hF0, 0, 1, 0, 32'hDEAD_BEEF, 0, 1, 1);
    add(1, 'hBE, 0, 0, 0, 0, 0, 1, 1);
    add(1, 'hAD, 0, 0, 0, 0, 0, 1, 1);
    add(1, 'hDE, 0, 0, 0, 0, 0, 1, 1);
    add(0, 'h00, 0, 0, 0, 0, 0, 1, 1);
`else
    add(0, 'h00, 0, 1, 0, 32'hDEAD_BEEF, 0, 1, 1);
`endif
    for (int i = 0; i < HOLD; i++) add(0, 'h00, 0, 0, 0, 0, 0, 0, 1);
    add(0, 'h00, 0, 0, 0, 0, 1, 0, 0);
    add(0, 'h00, 0, 0, 0, 0, 1, 0, 0);

    // ---- reset state ----
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
    chk("reset_ctl", 32'({InReady, CoreRstN, ROMWE, Busy, Err, ErrCode}), 32'b0001000);
    chk("reset_addr", 32'(ROMWADDR), 32'd0);
    chk("reset_data", ROMWData, 32'd0);
    @(negedge CLK);
    chk("ready_after_reset", 32'(InReady), 32'd1);

    // ---- apply vector table ----
    foreach (vecs[i]) begin
      InValid = vecs[i].vld;
      InData  = vecs[i].dat;
      Reboot  = vecs[i].rb;
      chk($sformatf("vec%0d_ctl", i), 32'({ROMWE, CoreRstN, InReady, Busy, Err, ErrCode}),
          32'({vecs[i].we, vecs[i].rstn, vecs[i].rdy, vecs[i].busy, 3'b000}));
      if (vecs[i].we)
        chk($sformatf("vec%0d_wr", i), {ROMWData[31:AW], ROMWADDR} ^ ROMWData,
            {vecs[i].data[31:AW], vecs[i].addr} ^ vecs[i].data);
      if (vecs[i].we)
        chk($sformatf("vec%0d_wdata", i), ROMWData, vecs[i].data);
      @(negedge CLK);
    end
    InValid = 1'b0;
    Reboot  = 1'b0;

    mon_en = 1'b1;

    // ---- N=0: no writes, release after hold ----
    do_reset();
    frame(0, 32'h0);
    expect_release("n0_release");

    // ---- N=2^ADDR_W: largest legal image, address wraps only after it ----
    do_reset();
    frame(16, 32'h1357_0011);
    expect_release("n16_release");
    chk("n16_writes_left", 32'(exp_wr.size()), 32'd0);

    // ---- N=17: length overflow ----
    do_reset();
    send_word(32'd17);
    InValid = 1'b0;
    @(negedge CLK);
    chk("len_err", 32'({Err, ErrCode, CoreRstN, InReady, Busy}), 32'b1_01_0_0_0);
    InValid = 1'b1;
    InData  = 8'h55;
    repeat (3) @(negedge CLK);
    InValid = 1'b0;
    chk("len_err_sticky", 32'({Err, ErrCode, CoreRstN}), 32'b1_01_0);

    // ---- idle link before header never times out ----
    do_reset();
    repeat (40) @(negedge CLK);
    chk("idle_hdr_no_tmo", 32'({Err, Busy}), 32'b01);

    // ---- timeout after a partial header ----
    send(8'h01);
    InValid = 1'b0;
    repeat (15) @(negedge CLK);
    chk("hdr_tmo_before", 32'(Err), 32'd0);
    @(negedge CLK);
    chk("hdr_tmo", 32'({Err, ErrCode}), 32'b1_10);

    // ---- timeout in DATA after 2 bytes ----
    do_reset();
    send_word(32'd1);
    send(8'h11);
    send(8'h22);
    InValid = 1'b0;
    repeat (15) @(negedge CLK);
    chk("data_tmo_before", 32'(Err), 32'd0);
    @(negedge CLK);
    chk("data_tmo", 32'({Err, ErrCode, CoreRstN}), 32'b1_10_0);

    // ---- byte on the expiry cycle wins, then the frame completes ----
    do_reset();
    send_word(32'd1);
    send(8'h11);
    send(8'h22);
    InValid = 1'b0;
    repeat (15) @(negedge CLK);
    send(8'h33);
    InValid = 1'b0;
    chk("tmo_byte_wins", 32'({Err, ErrCode}), 32'b0_00);
    repeat (10) @(negedge CLK);
    chk("tmo_rearmed", 32'(Err), 32'd0);
    exp_wr.push_back({AW'(0), 32'h4433_2211});
    send(8'h44);
`ifdef BOOT_CHECKSUM_EN
    send_word(32'h4433_2212);
`endif
    expect_release("tmo_frame_release");

    // ---- asynchronous reset mid-word discards the partial word ----
    do_reset();
    send_word(32'd1);
    send(8'hAA);
    send(8'hBB);
    InValid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midword_reset", 32'({ROMWE, CoreRstN, InReady, Busy, Err}), 32'b0_0_0_1_0);
    @(negedge CLK);
    rst_n = 1'b1;
    @(negedge CLK);
    frame(1, 32'hCAFE_F00D);
    expect_release("after_reset_release");

`ifdef BOOT_CHECKSUM_EN
    // ---- checksum match and mismatch ----
    do_reset();
    exp_wr.push_back({AW'(0), 32'h0000_0005});
    send_word(32'd1);
    send_word(32'd5);
    send_word(32'd6);
    expect_release("chk_ok_release");
    do_reset();
    exp_wr.push_back({AW'(0), 32'h0000_0005});
    send_word(32'd1);
    send_word(32'd5);
    send_word(32'd7);
    InValid = 1'b0;
    @(negedge CLK);
    chk("chk_bad", 32'({Err, ErrCode, CoreRstN}), 32'b1_11_0);
`endif

    repeat (2) @(negedge CLK);
    chk("writes_pending", 32'(exp_wr.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, bad_cnt);
    $finish;
  end

endmodule
